// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter and fetch-request unit of the semiMIPS front end
module pc_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  pcsrc,
    input  logic [31:0] resolve_pc4,
    input  logic [15:0] branch_offset,
    input  logic [25:0] jump_index,
    input  logic        stall,
    input  logic        imem_ready,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        flush
);

    typedef enum logic [1:0] {
        BOOT    = 2'd0,
        RUN     = 2'd1,
        PENDING = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [31:0] pc_q, pc_next;
    logic [31:0] pend_addr, pend_next;
    logic [31:0] branch_target, jump_target, target;
    logic        redirect, fetch_ok;

    always_comb begin
        branch_target = resolve_pc4 + {{14{branch_offset[15]}}, branch_offset, 2'b00};
        jump_target   = {resolve_pc4[31:28], jump_index, 2'b00};
        redirect      = (pcsrc == 2'b01) || (pcsrc == 2'b10);
        target        = (pcsrc == 2'b10) ? jump_target : branch_target;
        fetch_ok      = imem_ready && !stall;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= BOOT;
            pc_q      <= RESET_VECTOR;
            pend_addr <= 32'h0000_0000;
        end else begin
            state     <= state_next;
            pc_q      <= pc_next;
            pend_addr <= pend_next;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc_q;
        pend_next  = pend_addr;
        imem_req   = 1'b0;
        flush      = 1'b0;
        case (state)
            BOOT: begin
                state_next = RUN;
            end
            RUN: begin
                imem_req = 1'b1;
                if (redirect) begin
                    flush = 1'b1;
                    if (fetch_ok) begin
                        pc_next = target;
                    end else begin
                        pend_next  = target;
                        state_next = PENDING;
                    end
                end else if (fetch_ok) begin
                    pc_next = pc_q + 32'd4;
                end
            end
            PENDING: begin
                // The buffered redirect is older than anything arriving now, so it wins.
                if (fetch_ok) begin
                    pc_next    = pend_addr;
                    state_next = RUN;
                end
            end
            default: begin
                state_next = BOOT;
            end
        endcase
    end

    assign pc        = pc_q;
    assign imem_addr = pc_q;
    assign pc_plus4  = pc_q + 32'd4;

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - directed self-checking bench for pc_unit
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  pcsrc;
    logic [31:0] resolve_pc4;
    logic [15:0] branch_offset;
    logic [25:0] jump_index;
    logic        stall;
    logic        imem_ready;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        flush;

    int tests_run = 0;
    int tests_failed = 0;

    pc_unit #(.RESET_VECTOR(32'h0000_0000)) dut (
        .clk           (clk),
        .rst           (rst),
        .pcsrc         (pcsrc),
        .resolve_pc4   (resolve_pc4),
        .branch_offset (branch_offset),
        .jump_index    (jump_index),
        .stall         (stall),
        .imem_ready    (imem_ready),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .flush         (flush)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; pcsrc = 2'b00; resolve_pc4 = '0; branch_offset = '0;
        jump_index = '0; stall = 1'b0; imem_ready = 1'b1;

        // reset and boot
        tick(); tick();
        check("rst_req",   {31'd0, imem_req}, 32'd0);
        check("rst_pc",    pc, 32'h0);
        check("rst_flush", {31'd0, flush}, 32'd0);
        rst = 1'b0; #1;
        check("boot_req",   {31'd0, imem_req}, 32'd0);
        check("boot_flush", {31'd0, flush}, 32'd0);
        tick();
        check("run_req",  {31'd0, imem_req}, 32'd1);
        check("seq_a0",   imem_addr, 32'h0);
        tick();
        check("seq_a4",   imem_addr, 32'h4);
        tick();
        check("seq_a8",   imem_addr, 32'h8);
        check("seq_flush", {31'd0, flush}, 32'd0);

        // backward branch
        resolve_pc4 = 32'h100; branch_offset = 16'hFFFF; pcsrc = 2'b01; #1;
        check("br_flush", {31'd0, flush}, 32'd1);
        tick();
        pcsrc = 2'b00; #1;
        check("br_flush_off", {31'd0, flush}, 32'd0);
        check("br_addr", imem_addr, 32'h0000_00FC);

        // jump, then reserved pcsrc behaves as sequential
        resolve_pc4 = 32'h1000_0010; jump_index = 26'h40; pcsrc = 2'b10; #1;
        check("j_flush", {31'd0, flush}, 32'd1);
        tick();
        pcsrc = 2'b00; #1;
        check("j_addr", imem_addr, 32'h1000_0100);
        pcsrc = 2'b11; #1;
        check("rsv_flush", {31'd0, flush}, 32'd0);
        tick();
        pcsrc = 2'b00; #1;
        check("rsv_addr", imem_addr, 32'h1000_0104);

        // redirect while memory not ready: buffered, later redirect ignored
        imem_ready = 1'b0; resolve_pc4 = 32'h200; branch_offset = 16'h0; pcsrc = 2'b01; #1;
        check("pend_flush", {31'd0, flush}, 32'd1);
        tick();
        resolve_pc4 = 32'h0; jump_index = 26'hC0; pcsrc = 2'b10; #1;
        check("pend_flush2", {31'd0, flush}, 32'd0);
        check("pend_req",    {31'd0, imem_req}, 32'd0);
        check("pend_pc",     pc, 32'h1000_0104);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("pend_hold_req",   {31'd0, imem_req}, 32'd0);
            check("pend_hold_flush", {31'd0, flush}, 32'd0);
        end
        pcsrc = 2'b00; imem_ready = 1'b1; #1;
        check("pend_req_rdy", {31'd0, imem_req}, 32'd0);
        tick();
        check("pend_apply_req",  {31'd0, imem_req}, 32'd1);
        check("pend_apply_addr", imem_addr, 32'h200);

        // stall holds address
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_addr", imem_addr, 32'h200);
            check("stall_pc",   pc, 32'h200);
        end
        stall = 1'b0;
        tick();
        check("unstall_addr", imem_addr, 32'h204);

        // wrap at top of address space
        resolve_pc4 = 32'hF000_0000; jump_index = 26'h3FF_FFFF; pcsrc = 2'b10;
        tick();
        pcsrc = 2'b00; #1;
        check("top_addr",  imem_addr, 32'hFFFF_FFFC);
        check("top_plus4", pc_plus4, 32'h0);
        tick();
        check("wrap_addr", imem_addr, 32'h0);

        // reset while pending
        imem_ready = 1'b0; resolve_pc4 = 32'h200; branch_offset = 16'h0; pcsrc = 2'b01;
        tick();
        pcsrc = 2'b00; #1;
        check("pre_rst_req", {31'd0, imem_req}, 32'd0);
        rst = 1'b1;
        tick();
        check("midrst_req", {31'd0, imem_req}, 32'd0);
        check("midrst_pc",  pc, 32'h0);
        rst = 1'b0; imem_ready = 1'b1; #1;
        check("midrst_boot", {31'd0, imem_req}, 32'd0);
        tick();
        check("midrst_req1", {31'd0, imem_req}, 32'd1);
        check("midrst_a0",   imem_addr, 32'h0);
        tick();
        check("midrst_a4",   imem_addr, 32'h4);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
